servo_pwm_monitor: RTL and testbench

Single-channel servo PWM monitor: samples one servo control line (e.g. `pwm1`, `pwm2` or `catch_pwm` of the arm model) and measures pulse width and period. It converts each pulse width into a 0–180° angle. Sits on the receive side of the servo PWM interface; one instance is placed per servo line for self-check and closed-loop test of the arm controller. All outputs are synchronous to `clk`.

---
 rtl/servo_pwm_monitor.sv | 176 +++++++++++++++++
 tb/tb_servo_pwm_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_monitor.sv
// Single-channel servo PWM monitor: measures pulse width and period on one
// servo line and decodes the width into a 0..180 degree angle.
module servo_pwm_monitor #(
    parameter int unsigned MIN_W      = 25000,
    parameter int unsigned MAX_W      = 125000,
    parameter int unsigned STEP       = 556,
    parameter int unsigned PERIOD_NOM = 1000000,
    parameter int unsigned PERIOD_TOL = 50000,
    parameter int unsigned TIMEOUT    = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [31:0] width_o,
    output logic [7:0]  angle_o,
    output logic        valid_o,
    output logic        range_err_o,
    output logic        period_err_o,
    output logic        lost_o
);

    localparam logic [31:0] MIN_W_C   = 32'(MIN_W);
    localparam logic [31:0] MAX_W_C   = 32'(MAX_W);
    localparam logic [31:0] STEP_C    = 32'(STEP);
    localparam logic [31:0] HALF_C    = 32'(STEP / 2);
    localparam logic [31:0] P_HI_C    = 32'(PERIOD_NOM + PERIOD_TOL);
    localparam logic [31:0] P_LO_C    = 32'(PERIOD_NOM - PERIOD_TOL);
    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
    localparam logic [7:0]  Q_MAX     = 8'd180;

    typedef enum logic [1:0] {IDLE, HIGH, DIV, LOW} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  sync_reg;
    logic [31:0] hcnt_reg, hcnt_next;
    logic [31:0] pcnt_reg, pcnt_next;
    logic [31:0] w_reg, w_next;
    logic [31:0] r_reg, r_next;
    logic [7:0]  q_reg, q_next;
    logic        clamp_lo_reg, clamp_lo_next;
    logic [31:0] width_reg, width_next;
    logic [7:0]  angle_reg, angle_next;
    logic        valid_reg, valid_next;
    logic        range_err_reg, range_err_next;
    logic        period_err_reg, period_err_next;
    logic        lost_reg, lost_next;

    // sync_reg[1] is the synchronized line; sync_reg[2] is its previous value
    logic rise, fall;
    assign rise = sync_reg[1] & ~sync_reg[2];
    assign fall = ~sync_reg[1] & sync_reg[2];

    logic [31:0] hcnt_inc, pcnt_inc;
    assign hcnt_inc = (hcnt_reg == TIMEOUT_C) ? hcnt_reg : hcnt_reg + 32'd1;
    assign pcnt_inc = (pcnt_reg == TIMEOUT_C) ? pcnt_reg : pcnt_reg + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg       <= '0;
            state_reg      <= IDLE;
            hcnt_reg       <= '0;
            pcnt_reg       <= '0;
            w_reg          <= '0;
            r_reg          <= '0;
            q_reg          <= '0;
            clamp_lo_reg   <= 1'b0;
            width_reg      <= '0;
            angle_reg      <= '0;
            valid_reg      <= 1'b0;
            range_err_reg  <= 1'b0;
            period_err_reg <= 1'b0;
            lost_reg       <= 1'b1;
        end else begin
            sync_reg       <= {sync_reg[1:0], pwm_in};
            state_reg      <= state_next;
            hcnt_reg       <= hcnt_next;
            pcnt_reg       <= pcnt_next;
            w_reg          <= w_next;
            r_reg          <= r_next;
            q_reg          <= q_next;
            clamp_lo_reg   <= clamp_lo_next;
            width_reg      <= width_next;
            angle_reg      <= angle_next;
            valid_reg      <= valid_next;
            range_err_reg  <= range_err_next;
            period_err_reg <= period_err_next;
            lost_reg       <= lost_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        hcnt_next       = hcnt_reg;
        pcnt_next       = pcnt_reg;
        w_next          = w_reg;
        r_next          = r_reg;
        q_next          = q_reg;
        clamp_lo_next   = clamp_lo_reg;
        width_next      = width_reg;
        angle_next      = angle_reg;
        valid_next      = 1'b0;
        range_err_next  = range_err_reg;
        period_err_next = 1'b0;
        lost_next       = lost_reg;
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next = HIGH;
                    hcnt_next  = 32'd1;
                    pcnt_next  = 32'd1;
                    lost_next  = 1'b0;
                end
            end
            HIGH: begin
                // An edge takes priority over a same-cycle saturation timeout
                if (fall) begin
                    state_next    = DIV;
                    w_next        = hcnt_reg;
                    r_next        = hcnt_reg - MIN_W_C + HALF_C;
                    q_next        = '0;
                    clamp_lo_next = (hcnt_reg < MIN_W_C);
                    pcnt_next     = pcnt_inc;
                end else if (hcnt_reg == TIMEOUT_C) begin
                    state_next = IDLE;
                    lost_next  = 1'b1;
                end else begin
                    hcnt_next = hcnt_inc;
                    pcnt_next = pcnt_inc;
                end
            end
            DIV: begin
                if (rise) begin
                    // Low time shorter than the divide: drop this measurement
                    state_next      = HIGH;
                    hcnt_next       = 32'd1;
                    pcnt_next       = 32'd1;
                    period_err_next = 1'b1;
                end else begin
                    pcnt_next = pcnt_inc;
                    if (!clamp_lo_reg && (r_reg >= STEP_C) && (q_reg < Q_MAX)) begin
                        r_next = r_reg - STEP_C;
                        q_next = q_reg + 8'd1;
                    end else begin
                        state_next     = LOW;
                        valid_next     = 1'b1;
                        width_next     = w_reg;
                        angle_next     = clamp_lo_reg ? 8'd0 : q_reg;
                        range_err_next = clamp_lo_reg || (w_reg > MAX_W_C);
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_next      = HIGH;
                    hcnt_next       = 32'd1;
                    pcnt_next       = 32'd1;
                    period_err_next = (pcnt_reg > P_HI_C) || (pcnt_reg < P_LO_C);
                end else if (pcnt_reg == TIMEOUT_C) begin
                    state_next = IDLE;
                    lost_next  = 1'b1;
                end else begin
                    pcnt_next = pcnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign width_o      = width_reg;
    assign angle_o      = angle_reg;
    assign valid_o      = valid_reg;
    assign range_err_o  = range_err_reg;
    assign period_err_o = period_err_reg;
    assign lost_o       = lost_reg;

endmodule

// File: tb/tb_servo_pwm_monitor.sv
// Directed bench for servo_pwm_monitor using scaled-down timing parameters
// (MIN_W=100, MAX_W=1000, STEP=5, period 2000 +/-100, timeout 4000).
module tb_servo_pwm_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [31:0] width_o;
    logic [7:0]  angle_o;
    logic        valid_o;
    logic        range_err_o;
    logic        period_err_o;
    logic        lost_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int v_cnt = 0;
    int pe_cnt = 0;
    int last_vcyc = 0;
    logic [31:0] last_w = '0;
    logic [7:0]  last_a = '0;
    logic        last_re = 1'b0;

    servo_pwm_monitor #(
        .MIN_W(100), .MAX_W(1000), .STEP(5),
        .PERIOD_NOM(2000), .PERIOD_TOL(100), .TIMEOUT(4000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
        .width_o(width_o), .angle_o(angle_o), .valid_o(valid_o),
        .range_err_o(range_err_o), .period_err_o(period_err_o), .lost_o(lost_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record output events on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o) begin
                v_cnt++;
                last_vcyc = cyc;
                last_w    = width_o;
                last_a    = angle_o;
                last_re   = range_err_o;
            end
            if (period_err_o) pe_cnt++;
        end
    end

    // Called at #1 after a posedge; holds the line at v for exactly n cycles
    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int h, input int l);
        hold(1'b1, h);
        fall_cyc = cyc;
        hold(1'b0, l);
        $display("[TB] pulse high=%0d low=%0d valids=%0d period_errs=%0d width=%0d angle=%0d range_err=%0b lost=%0b",
                 h, l, v_cnt, pe_cnt, last_w, last_a, last_re, lost_o);
    endtask

    task automatic test_reset();
        tests++; if (lost_o !== 1'b1) begin fails++; $display("FAIL reset_lost got=%0b exp=1", lost_o); end
        tests++; if (width_o !== 32'd0) begin fails++; $display("FAIL reset_width got=%0d exp=0", width_o); end
        tests++; if (angle_o !== 8'd0) begin fails++; $display("FAIL reset_angle got=%0d exp=0", angle_o); end
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
        tests++; if (range_err_o !== 1'b0) begin fails++; $display("FAIL reset_range got=%0b exp=0", range_err_o); end
        tests++; if (period_err_o !== 1'b0) begin fails++; $display("FAIL reset_perr got=%0b exp=0", period_err_o); end
    endtask

    task automatic test_nominal();
        int v0, p0;
        v0 = v_cnt; p0 = pe_cnt;
        pulse(550, 1450);
        pulse(550, 1450);
        tests++; if (v_cnt - v0 !== 2) begin fails++; $display("FAIL nom_valids got=%0d exp=2", v_cnt - v0); end
        tests++; if (last_w !== 32'd550) begin fails++; $display("FAIL nom_width got=%0d exp=550", last_w); end
        tests++; if (last_a !== 8'd90) begin fails++; $display("FAIL nom_angle got=%0d exp=90", last_a); end
        tests++; if (last_re !== 1'b0) begin fails++; $display("FAIL nom_range got=%0b exp=0", last_re); end
        tests++; if (last_vcyc - fall_cyc !== 94) begin fails++; $display("FAIL nom_latency got=%0d exp=94", last_vcyc - fall_cyc); end
        tests++; if (pe_cnt - p0 !== 0) begin fails++; $display("FAIL nom_perr got=%0d exp=0", pe_cnt - p0); end
        tests++; if (lost_o !== 1'b0) begin fails++; $display("FAIL nom_lost got=%0b exp=0", lost_o); end
        tests++; if (width_o !== 32'd550) begin fails++; $display("FAIL nom_hold_width got=%0d exp=550", width_o); end
    endtask

    task automatic test_endpoints();
        int ws[4] = '{100, 1000, 108, 107};
        int as[4] = '{0, 180, 2, 1};
        int lat[4] = '{4, 184, 6, 5};
        for (int i = 0; i < 4; i++) begin
            pulse(ws[i], 2000 - ws[i]);
            tests++; if (last_a !== 8'(as[i])) begin fails++; $display("FAIL ep_angle w=%0d got=%0d exp=%0d", ws[i], last_a, as[i]); end
            tests++; if (last_re !== 1'b0) begin fails++; $display("FAIL ep_range w=%0d got=%0b exp=0", ws[i], last_re); end
            tests++; if (last_w !== 32'(ws[i])) begin fails++; $display("FAIL ep_width got=%0d exp=%0d", last_w, ws[i]); end
            tests++; if (last_vcyc - fall_cyc !== lat[i]) begin fails++; $display("FAIL ep_latency w=%0d got=%0d exp=%0d", ws[i], last_vcyc - fall_cyc, lat[i]); end
        end
    endtask

    task automatic test_out_of_range();
        pulse(50, 1950);
        tests++; if (last_w !== 32'd50) begin fails++; $display("FAIL oor_lo_width got=%0d exp=50", last_w); end
        tests++; if (last_a !== 8'd0) begin fails++; $display("FAIL oor_lo_angle got=%0d exp=0", last_a); end
        tests++; if (last_re !== 1'b1) begin fails++; $display("FAIL oor_lo_range got=%0b exp=1", last_re); end
        tests++; if (last_vcyc - fall_cyc !== 4) begin fails++; $display("FAIL oor_lo_latency got=%0d exp=4", last_vcyc - fall_cyc); end
        pulse(1100, 900);
        tests++; if (last_w !== 32'd1100) begin fails++; $display("FAIL oor_hi_width got=%0d exp=1100", last_w); end
        tests++; if (last_a !== 8'd180) begin fails++; $display("FAIL oor_hi_angle got=%0d exp=180", last_a); end
        tests++; if (last_re !== 1'b1) begin fails++; $display("FAIL oor_hi_range got=%0b exp=1", last_re); end
        tests++; if (last_vcyc - fall_cyc !== 184) begin fails++; $display("FAIL oor_hi_latency got=%0d exp=184", last_vcyc - fall_cyc); end
    endtask

    task automatic test_period();
        int p0;
        p0 = pe_cnt;
        for (int i = 0; i < 3; i++) pulse(550, 1950);
        tests++; if (pe_cnt - p0 !== 2) begin fails++; $display("FAIL per_long got=%0d exp=2", pe_cnt - p0); end
        pulse(550, 1454);
        p0 = pe_cnt;
        pulse(550, 1454);
        pulse(550, 1550);
        pulse(550, 1551);
        pulse(550, 1450);
        tests++; if (pe_cnt - p0 !== 1) begin fails++; $display("FAIL per_tol_hi got=%0d exp=1", pe_cnt - p0); end
        p0 = pe_cnt;
        pulse(550, 1350);
        pulse(550, 1349);
        pulse(550, 1450);
        tests++; if (pe_cnt - p0 !== 1) begin fails++; $display("FAIL per_tol_lo got=%0d exp=1", pe_cnt - p0); end
    endtask

    task automatic test_lost_low();
        int v0, p0;
        hold(1'b0, 4200);
        tests++; if (lost_o !== 1'b1) begin fails++; $display("FAIL lostlo_set got=%0b exp=1", lost_o); end
        v0 = v_cnt; p0 = pe_cnt;
        pulse(550, 1450);
        tests++; if (lost_o !== 1'b0) begin fails++; $display("FAIL lostlo_clear got=%0b exp=0", lost_o); end
        tests++; if (v_cnt - v0 !== 1) begin fails++; $display("FAIL lostlo_valid got=%0d exp=1", v_cnt - v0); end
        tests++; if (pe_cnt - p0 !== 0) begin fails++; $display("FAIL lostlo_perr got=%0d exp=0", pe_cnt - p0); end
    endtask

    task automatic test_lost_high();
        int v0, p0;
        v0 = v_cnt; p0 = pe_cnt;
        hold(1'b1, 4200);
        hold(1'b0, 500);
        $display("[TB] stuck high 4200 then low 500 lost=%0b", lost_o);
        tests++; if (lost_o !== 1'b1) begin fails++; $display("FAIL losthi_set got=%0b exp=1", lost_o); end
        tests++; if (v_cnt - v0 !== 0) begin fails++; $display("FAIL losthi_valid got=%0d exp=0", v_cnt - v0); end
        tests++; if (pe_cnt - p0 !== 0) begin fails++; $display("FAIL losthi_perr got=%0d exp=0", pe_cnt - p0); end
    endtask

    task automatic test_glitch();
        int v0, p0;
        v0 = v_cnt; p0 = pe_cnt;
        pulse(1000, 50);
        pulse(550, 1450);
        tests++; if (v_cnt - v0 !== 1) begin fails++; $display("FAIL glitch_valid got=%0d exp=1", v_cnt - v0); end
        tests++; if (pe_cnt - p0 !== 1) begin fails++; $display("FAIL glitch_perr got=%0d exp=1", pe_cnt - p0); end
        tests++; if (last_w !== 32'd550) begin fails++; $display("FAIL glitch_width got=%0d exp=550", last_w); end
        tests++; if (lost_o !== 1'b0) begin fails++; $display("FAIL glitch_lost got=%0b exp=0", lost_o); end
    endtask

    task automatic test_reset_mid();
        int v0;
        hold(1'b1, 300);
        #3 rst_n = 1'b0;
        #1;
        $display("[TB] reset mid-high width=%0d angle=%0d lost=%0b", width_o, angle_o, lost_o);
        tests++; if (lost_o !== 1'b1) begin fails++; $display("FAIL rmid_lost got=%0b exp=1", lost_o); end
        tests++; if (width_o !== 32'd0) begin fails++; $display("FAIL rmid_width got=%0d exp=0", width_o); end
        tests++; if (angle_o !== 8'd0) begin fails++; $display("FAIL rmid_angle got=%0d exp=0", angle_o); end
        tests++; if (range_err_o !== 1'b0) begin fails++; $display("FAIL rmid_range got=%0b exp=0", range_err_o); end
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        v0 = v_cnt;
        hold(1'b0, 300);
        tests++; if (lost_o !== 1'b1) begin fails++; $display("FAIL rmid_after_lost got=%0b exp=1", lost_o); end
        tests++; if (v_cnt - v0 !== 0) begin fails++; $display("FAIL rmid_after_valid got=%0d exp=0", v_cnt - v0); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        hold(1'b0, 5);
        test_reset();
        test_nominal();
        test_endpoints();
        test_out_of_range();
        test_period();
        test_lost_low();
        test_lost_high();
        test_glitch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
